// File: rtl/sprite_pkg.sv
// sprite_pkg: shared types and constants for the character sprite fetch path.
// Contents: transparent palette key, screen geometry, coordinate width,
// palette-index and 12-bit RGB types.
package sprite_pkg;

    typedef logic [3:0] pal_idx_t;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb12_t;

    // Magenta colour key: pixels with this index are never drawn.
    localparam pal_idx_t TRANSP_IDX = 4'h1;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int COORD_W  = 10;

endpackage

// File: rtl/ryu_crouch_fetch_if.sv
// ryu_crouch_fetch_if: bundle between the VGA timing/ROM side and the fetch stage.
// slave  : the fetch stage (consumes position/draw/ROM data, drives ROM address and pixel out)
// master : the surrounding video logic
// Signals: frame_start, sprite_x, sprite_y, facing_left, anim_restart,
//          draw_x, draw_y, pix_en, rom_addr, rom_data, pal_index, pix_valid
interface ryu_crouch_fetch_if
    import sprite_pkg::*;
#(
    parameter int ADDR_W = 14
);
    logic               frame_start;
    logic [COORD_W-1:0] sprite_x;
    logic [COORD_W-1:0] sprite_y;
    logic               facing_left;
    logic               anim_restart;
    logic [COORD_W-1:0] draw_x;
    logic [COORD_W-1:0] draw_y;
    logic               pix_en;
    logic [ADDR_W-1:0]  rom_addr;
    pal_idx_t           rom_data;
    pal_idx_t           pal_index;
    logic               pix_valid;

    modport slave (
        input  frame_start, sprite_x, sprite_y, facing_left, anim_restart,
               draw_x, draw_y, pix_en, rom_data,
        output rom_addr, pal_index, pix_valid
    );

    modport master (
        output frame_start, sprite_x, sprite_y, facing_left, anim_restart,
               draw_x, draw_y, pix_en, rom_data,
        input  rom_addr, pal_index, pix_valid
    );
endinterface

// File: rtl/anim_frame_counter.sv
// anim_frame_counter: animation frame sequencer shared by the character sprites.
// Ports: Clk, Reset_n (async, active low), frame_start (vblank pulse),
//        anim_restart (sticky request to restart at frame 0), frame (current frame).
// The frame advances once every FRAME_DIV frame_start pulses, modulo N_FRAMES.
module anim_frame_counter #(
    parameter int FRAME_DIV = 8,
    parameter int N_FRAMES  = 4,
    parameter int FRM_W     = (N_FRAMES > 1) ? $clog2(N_FRAMES) : 1
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             frame_start,
    input  logic             anim_restart,
    output logic [FRM_W-1:0] frame
);
    localparam int DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

    logic [DIV_W-1:0] div;
    logic             restart_seen;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            frame        <= '0;
            div          <= '0;
            restart_seen <= 1'b0;
        end else if (frame_start) begin
            restart_seen <= 1'b0;
            // A restart request arriving together with frame_start still counts.
            if (restart_seen || anim_restart) begin
                frame <= '0;
                div   <= '0;
            end else if (div == DIV_W'(FRAME_DIV - 1)) begin
                div   <= '0;
                frame <= (frame == FRM_W'(N_FRAMES - 1)) ? '0 : frame + FRM_W'(1);
            end else begin
                div <= div + DIV_W'(1);
            end
        end else if (anim_restart) begin
            restart_seen <= 1'b1;
        end
    end
endmodule

// File: rtl/ryu_crouch_fetch.sv
// ryu_crouch_fetch: crouch sprite ROM address generation and pixel qualification.
// Ports: Clk, Reset_n (async, active low), bus (ryu_crouch_fetch_if.slave):
//   in : frame_start, sprite_x/y, facing_left, anim_restart, draw_x/y, pix_en, rom_data
//   out: rom_addr (registered), pal_index, pix_valid
// Latency draw_x/draw_y -> pal_index/pix_valid is ROM_LAT+2 cycles, no backpressure.
// Build option: define SPRITE_FLIP_EN to enable horizontal mirroring via facing_left;
// without it facing_left is ignored.
module ryu_crouch_fetch
    import sprite_pkg::*;
#(
    parameter int SPR_W     = 64,
    parameter int SPR_H     = 64,
    parameter int N_FRAMES  = 4,
    parameter int FRAME_DIV = 8,
    parameter int ROM_LAT   = 1,
    parameter int ADDR_W    = 14
) (
    input  logic                Clk,
    input  logic                Reset_n,
    ryu_crouch_fetch_if.slave   bus
);
    localparam int XW    = $clog2(SPR_W);
    localparam int YW    = (SPR_H > 1) ? $clog2(SPR_H) : 1;
    localparam int FRM_W = (N_FRAMES > 1) ? $clog2(N_FRAMES) : 1;
    localparam int CW1   = COORD_W + 1;

    logic [COORD_W-1:0] sx, sy;
    logic               armed;
    logic [FRM_W-1:0]   frame;

    logic               hit;
    logic [CW1-1:0]     x_ext, y_ext, sx_ext, sy_ext, sx_end, sy_end;
    logic [XW-1:0]      dx, col;
    logic [YW-1:0]      dy;
    logic [ADDR_W-1:0]  addr_next;

    logic [ADDR_W-1:0]  rom_addr_q;
    logic [ROM_LAT:0]   hit_sr;
    logic               hit_d;
    pal_idx_t           pal_q;
    logic               valid_q;

    anim_frame_counter #(
        .FRAME_DIV (FRAME_DIV),
        .N_FRAMES  (N_FRAMES),
        .FRM_W     (FRM_W)
    ) u_anim (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .frame_start  (bus.frame_start),
        .anim_restart (bus.anim_restart),
        .frame        (frame)
    );

    // Position is sampled only at vblank so a sprite never tears mid-frame.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sx    <= '0;
            sy    <= '0;
            armed <= 1'b0;
        end else if (bus.frame_start) begin
            sx    <= bus.sprite_x;
            sy    <= bus.sprite_y;
            armed <= 1'b1;
        end
    end

`ifdef SPRITE_FLIP_EN
    logic face;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)
            face <= 1'b0;
        else if (bus.frame_start)
            face <= bus.facing_left;
    end

    // SPR_W is a power of two, so SPR_W-1-dx is the bitwise inverse of dx.
    assign col = face ? ~dx : dx;
`else
    assign col = dx;
`endif

    // One extra bit on the compares so a box crossing 1023 clips instead of wrapping.
    assign x_ext  = {1'b0, bus.draw_x};
    assign y_ext  = {1'b0, bus.draw_y};
    assign sx_ext = {1'b0, sx};
    assign sy_ext = {1'b0, sy};
    assign sx_end = sx_ext + CW1'(SPR_W);
    assign sy_end = sy_ext + CW1'(SPR_H);

    assign hit = bus.pix_en & armed &
                 (x_ext >= sx_ext) & (x_ext < sx_end) &
                 (y_ext >= sy_ext) & (y_ext < sy_end);

    // Only offsets inside the box matter, so the low bits of the difference suffice.
    assign dx = bus.draw_x[XW-1:0] - sx[XW-1:0];
    assign dy = bus.draw_y[YW-1:0] - sy[YW-1:0];

    assign addr_next = ADDR_W'(frame) * ADDR_W'(SPR_W * SPR_H) +
                       ADDR_W'(dy) * ADDR_W'(SPR_W) + ADDR_W'(col);

    assign hit_d = hit_sr[ROM_LAT];

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rom_addr_q <= '0;
            hit_sr     <= '0;
            pal_q      <= '0;
            valid_q    <= 1'b0;
        end else begin
            if (hit)
                rom_addr_q <= addr_next;
            hit_sr  <= {hit_sr[ROM_LAT-1:0], hit};
            pal_q   <= hit_d ? bus.rom_data : '0;
            valid_q <= hit_d && (bus.rom_data != TRANSP_IDX);
        end
    end

    assign bus.rom_addr  = rom_addr_q;
    assign bus.pal_index = pal_q;
    assign bus.pix_valid = valid_q;
endmodule

// File: tb/tb_ryu_crouch_fetch.sv
module tb_ryu_crouch_fetch;
    import sprite_pkg::*;

    localparam int ADDR_W = 14;

    logic Clk = 1'b0;
    logic Reset_n = 1'b0;

    ryu_crouch_fetch_if #(.ADDR_W(ADDR_W)) bus ();

    ryu_crouch_fetch #(
        .SPR_W     (64),
        .SPR_H     (64),
        .N_FRAMES  (4),
        .FRAME_DIV (8),
        .ROM_LAT   (1),
        .ADDR_W    (ADDR_W)
    ) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    always #5 Clk = ~Clk;

    function automatic logic [3:0] rom_word(input logic [13:0] a);
        logic [3:0] v;
        v = a[3:0] + 4'd3 + {2'b00, a[13:12]} * 4'd5;
        return v;
    endfunction

    // Single-cycle synchronous ROM
    always @(posedge Clk) bus.rom_data <= rom_word(bus.rom_addr);

    typedef struct {
        logic [3:0] pal;
        logic       vld;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    int          m_sx, m_sy, m_frame, m_div;
    bit          m_face, m_armed, m_restart;
    logic [13:0] m_addr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_sx = 0; m_sy = 0; m_face = 0; m_armed = 0;
        m_frame = 0; m_div = 0; m_restart = 0; m_addr = '0;
    endtask

    // One pixel clock: drive, predict, clock, then compare
    task automatic cyc(input int x, input int y, input bit en, input bit fs);
        exp_t e;
        bit hit;
        int dx, dy, col;
        bus.draw_x      = 10'(x);
        bus.draw_y      = 10'(y);
        bus.pix_en      = en;
        bus.frame_start = fs;
        hit = en && m_armed && x >= m_sx && x < m_sx + 64 && y >= m_sy && y < m_sy + 64;
        if (hit) begin
            dx  = x - m_sx;
            dy  = y - m_sy;
            col = dx;
`ifdef SPRITE_FLIP_EN
            if (m_face) col = 63 - dx;
`endif
            m_addr = 14'(m_frame * 4096 + dy * 64 + col);
        end
        e.pal = hit ? rom_word(m_addr) : 4'h0;
        e.vld = hit && (rom_word(m_addr) != 4'h1);
        q.push_back(e);
        if (fs) begin
            m_sx = int'(bus.sprite_x);
            m_sy = int'(bus.sprite_y);
            m_face = bus.facing_left;
            m_armed = 1;
            if (m_restart || bus.anim_restart) begin
                m_frame = 0; m_div = 0;
            end else if (m_div == 7) begin
                m_div = 0; m_frame = (m_frame + 1) % 4;
            end else begin
                m_div++;
            end
            m_restart = 0;
        end else if (bus.anim_restart) begin
            m_restart = 1;
        end
        @(posedge Clk);
        #1;
        check("rom_addr", bus.rom_addr, m_addr);
        if (q.size() == 3) begin
            e = q.pop_front();
            check("pal_index", bus.pal_index, e.pal);
            check("pix_valid", bus.pix_valid, e.vld);
        end
        bus.frame_start  = 1'b0;
        bus.anim_restart = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
    endtask

    task automatic pulses(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 1);
    endtask

    initial begin
        bus.frame_start = 0; bus.sprite_x = 0; bus.sprite_y = 0;
        bus.facing_left = 0; bus.anim_restart = 0;
        bus.draw_x = 0; bus.draw_y = 0; bus.pix_en = 0;
        model_reset();

        repeat (2) @(posedge Clk);
        #1;
        check("reset_rom_addr", bus.rom_addr, 14'd0);
        check("reset_pal_index", bus.pal_index, 4'd0);
        check("reset_pix_valid", bus.pix_valid, 1'b0);
        Reset_n = 1'b1;

        // Not armed yet: nothing drawn
        bus.sprite_x = 10'd100; bus.sprite_y = 10'd200;
        cyc(100, 200, 1, 0);
        cyc(110, 210, 1, 0);
        cyc(120, 230, 1, 0);
        idle(3);

        // Arm and draw around the box edges
        pulses(1);
        cyc(100, 200, 1, 0);
        check("first_addr", bus.rom_addr, 14'd0);
        cyc(99, 200, 1, 0);
        cyc(164, 200, 1, 0);
        cyc(163, 263, 1, 0);
        cyc(114, 200, 1, 0);   // transparent word
        cyc(120, 200, 1, 0);
        cyc(100, 264, 1, 0);
        idle(3);

        // Mirroring
        bus.facing_left = 1'b1;
        pulses(1);
        cyc(100, 201, 1, 0);
`ifdef SPRITE_FLIP_EN
        check("facing_addr", bus.rom_addr, 14'd127);
`else
        check("facing_addr", bus.rom_addr, 14'd64);
`endif
        bus.facing_left = 1'b0;
        idle(3);

        // Animation: restart, step, wrap, sticky restart
        bus.anim_restart = 1'b1;
        pulses(1);
        pulses(8);
        cyc(100, 200, 1, 0);
        check("frame1_addr", bus.rom_addr, 14'd4096);
        pulses(24);
        cyc(100, 200, 1, 0);
        check("frame_wrap_addr", bus.rom_addr, 14'd0);
        pulses(8);
        bus.anim_restart = 1'b1;
        cyc(0, 0, 0, 0);
        cyc(101, 200, 1, 0);
        check("restart_pending_addr", bus.rom_addr, 14'd4097);
        pulses(1);
        cyc(100, 200, 1, 0);
        check("restart_addr", bus.rom_addr, 14'd0);
        idle(3);

        // Right-edge clipping and mid-frame position changes
        bus.sprite_x = 10'd1000;
        pulses(1);
        cyc(1023, 200, 1, 0);
        check("edge_addr", bus.rom_addr, 14'd23);
        cyc(5, 200, 1, 0);
        check("no_wrap_hold", bus.rom_addr, 14'd23);
        bus.sprite_x = 10'd300;
        cyc(1010, 200, 1, 0);
        check("mid_frame_addr", bus.rom_addr, 14'd10);
        cyc(300, 200, 1, 0);

        // frame_start coincident with a draw uses the old position
        bus.sprite_x = 10'd100;
        cyc(1001, 200, 1, 1);
        check("coincident_addr", bus.rom_addr, 14'd1);
        cyc(1001, 200, 1, 0);
        cyc(102, 200, 1, 0);
        idle(3);

        // Asynchronous reset in the middle of a line
        cyc(100, 200, 1, 0);
        cyc(101, 200, 1, 0);
        cyc(102, 200, 1, 0);
        check("pre_reset_valid", bus.pix_valid, 1'b1);
        #2;
        Reset_n = 1'b0;
        #1;
        check("async_pix_valid", bus.pix_valid, 1'b0);
        check("async_pal_index", bus.pal_index, 4'd0);
        check("async_rom_addr", bus.rom_addr, 14'd0);
        q.delete();
        model_reset();
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        cyc(100, 200, 1, 0);
        cyc(130, 230, 1, 0);
        cyc(150, 250, 1, 0);
        idle(3);
        pulses(1);
        cyc(105, 210, 1, 0);
        cyc(106, 210, 1, 0);
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ryu_crouch_fetch.md
Name: ryu_crouch_fetch

Overview:
Upstream stage of the crouch palette lookup. It takes the VGA controller's current draw coordinates and the sprite's screen position. It generates the sprite ROM address (with animation-frame offset and optional mirroring), aligns a hit flag to the ROM read latency, and drives the 4-bit palette index plus an opaque-pixel valid to the palette stage and the layer mux.

Parameters:
SPR_W, 64, sprite width in pixels (power of two)
SPR_H, 64, sprite height in pixels
N_FRAMES, 4, animation frames stored back-to-back in ROM
FRAME_DIV, 8, video frames per animation step (>=1)
ROM_LAT, 1, ROM read latency in cycles (1 or 2)
ADDR_W, 14, ROM address width, equal to clog2(SPR_W*SPR_H*N_FRAMES)

Ports:
Clk  in  1  pixel clock
Reset_n  in  1  asynchronous active-low reset
frame_start  in  1  one-cycle pulse at start of vertical blank
sprite_x  in  10  sprite left edge, screen pixels, unsigned
sprite_y  in  10  sprite top edge, screen pixels, unsigned
facing_left  in  1  mirror sprite horizontally
anim_restart  in  1  restart animation at frame 0 on next frame_start
draw_x  in  10  current pixel column
draw_y  in  10  current pixel row
pix_en  in  1  active-video strobe for draw_x/draw_y
rom_addr  out  ADDR_W  sprite ROM address, registered
rom_data  in  4  palette index from ROM, ROM_LAT cycles after rom_addr
pal_index  out  4  palette index to palette stage
pix_valid  out  1  pixel inside sprite box and not transparent

Behaviour:
- Reset: all outputs 0. Shadow position/facing registers 0. armed=0 (no hits until the first frame_start). Anim frame=0, divider=0. Hit pipeline cleared.
- Shadow latch: on frame_start, latch sprite_x, sprite_y and facing_left into shadow registers and set armed=1. Mid-frame input changes never tear. A pixel presented in the same cycle as frame_start uses the old shadow values.
- Animation: on frame_start, divider increments.
  - When divider reaches FRAME_DIV-1, it wraps to 0 and frame advances modulo N_FRAMES (N_FRAMES-1 wraps to 0).
  - If anim_restart was seen since the previous frame_start (sticky flag), that frame_start instead sets frame=0 and divider=0, then clears the flag.
  - Frame and divider change only on frame_start.
- Stage 0 (compare/address): hit = pix_en & armed & (draw_x >= sx) & (draw_x < sx+SPR_W) & (draw_y >= sy) & (draw_y < sy+SPR_H).
  - Compare sums are 11 bits wide, so a sprite crossing x=1023 or y=1023 clips and never wraps.
  - dx = draw_x-sx; dy = draw_y-sy.
  - col = facing ? SPR_W-1-dx : dx.
  - rom_addr <= frame*SPR_W*SPR_H + dy*SPR_W + col, registered.
  - When hit=0, rom_addr holds its previous value (no spurious ROM toggling).
- Stages 1..ROM_LAT: hit delayed through a ROM_LAT-deep shift register.
- Output stage: pal_index <= rom_data; pix_valid <= hit_d & (rom_data != TRANSP_IDX).
  - When hit_d=0: pal_index=0 and pix_valid=0.
- Latency: draw_x/draw_y to pal_index/pix_valid is ROM_LAT+2 cycles (3 at default). It is fixed, with no backpressure; the VGA controller delays its blanking by the same amount.
- Reset asserted mid-line: outputs drop to 0 asynchronously. After release, nothing is drawn until the next frame_start.

Optional Feature:
SPRITE_FLIP_EN. When defined, facing_left is latched and mirroring is applied as above. When undefined, facing_left is ignored, col=dx always, and the shadow facing register and subtractor are removed.

Decomposition:
- Package sprite_pkg:
  - TRANSP_IDX=4'h1 (magenta key)
  - SCREEN_W=640, SCREEN_H=480
  - COORD_W=10
  - typedef pal_idx_t (logic [3:0])
  - typedef rgb12_t (struct of three 4-bit channels)
- Sub-module anim_frame_counter: frame_start, anim_restart, FRAME_DIV and N_FRAMES in; frame out. It is reused by the other character sprites.

Test Plan:
- Reset then draw inside box before any frame_start -> pix_valid=0, pal_index=0 throughout.
- sprite_x=100, sprite_y=200, frame_start. Then draw (100,200) with ROM word 0 = 4'h3 -> rom_addr=0 one cycle later, pal_index=3 and pix_valid=1 three cycles after draw. Draw (99,200) or (164,200) -> pix_valid=0.
- Same box with facing_left=1 (SPRITE_FLIP_EN defined), draw (100,201) -> rom_addr=127. Undefined -> rom_addr=64.
- ROM returns 4'h1 inside box -> pix_valid=0 and pal_index=1. The next pixel returning 4'h9 -> pix_valid=1.
- FRAME_DIV=8: 8 frame_start pulses -> frame=1 and rom_addr base 4096. After 32 pulses, frame wraps to 0. anim_restart mid-frame -> frame=0 after the next frame_start.
- sprite_x=1000 and draw_x=1023 -> hit with dx=23, no wrap. Change sprite_x mid-frame -> no effect until frame_start. frame_start coincident with a draw -> old position used.
